// File: rtl/mips_pkg.sv
// Shared MIPS definitions used by the fetch front end and the control decoder.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b100000;

  typedef enum logic [1:0] {FS_IDLE, FS_FETCH, FS_HOLD} fetch_state_t;

  // Branch immediates count words, so the byte offset is the sign-extended field shifted by two.
  function automatic logic [31:0] branchOffset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_logic.sv
// Combinational next-PC selection for the fetch unit: jump beats branch beats sequential.
module next_pc_logic
  import mips_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] instr,
  input  logic        c_Jump,
  input  logic        c_PCSrc,
  output logic [31:0] next_pc
);

  logic unusedOpBits;
  assign unusedOpBits = ^instr[31:26];

  always_comb begin
    next_pc = pc_plus4;
    if (c_Jump) begin
      next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    end else if (c_PCSrc) begin
      next_pc = pc_plus4 + branchOffset(instr[15:0]);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: owns the PC, fetches over a req/ready handshake and holds
// the instruction for the decoder until downstream retires it.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        c_PCSrc,
  input  logic        c_Jump,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr_count
);

  fetch_state_t state_q;
  logic [31:0]  pc_q;
  logic [31:0]  pc_d;
  logic [31:0]  instr_q;
  logic [31:0]  count_q;
  logic [31:0]  count_d;
  logic         valid_q;
  logic         req_q;

  assign pc_plus4 = pc_q + 32'd4;
  assign count_d  = count_q + 32'd1;

  next_pc_logic u_next_pc (
    .pc_plus4 (pc_plus4),
    .instr    (instr_q),
    .c_Jump   (c_Jump),
    .c_PCSrc  (c_PCSrc),
    .next_pc  (pc_d)
  );

  // Branch/jump inputs only matter on the retire edge; the mux output is ignored otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FS_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      count_q <= 32'h0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      case (state_q)
        FS_IDLE: begin
          state_q <= FS_FETCH;
          req_q   <= 1'b1;
        end
        FS_FETCH: begin
          if (imem_ready) begin
            instr_q <= imem_rdata;
            valid_q <= 1'b1;
            req_q   <= 1'b0;
            state_q <= FS_HOLD;
          end
        end
        FS_HOLD: begin
          if (!stall) begin
            pc_q    <= pc_d;
            count_q <= count_d;
            valid_q <= 1'b0;
            req_q   <= 1'b1;
            state_q <= FS_FETCH;
          end
        end
        default: begin
          state_q <= FS_IDLE;
          valid_q <= 1'b0;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign op          = instr_q[31:26];
  assign funct       = instr_q[5:0];
  assign instr_count = count_q;

endmodule
